// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus engine: state encoding, counter width,
// and the RTC chip register map.
package rtc_bus_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [3:0] {
        IDLE,
        A_SETUP,
        A_STROBE,
        A_HOLD,
        GAP,
        D_SETUP,
        D_STROBE,
        D_HOLD,
        DONE
    } bus_state_t;

    localparam logic [7:0] ADDR_SEG          = 8'h21;
    localparam logic [7:0] ADDR_MIN          = 8'h22;
    localparam logic [7:0] ADDR_HORA         = 8'h23;
    localparam logic [7:0] ADDR_DIA          = 8'h24;
    localparam logic [7:0] ADDR_MES          = 8'h25;
    localparam logic [7:0] ADDR_ANO          = 8'h26;
    localparam logic [7:0] ADDR_TIMER0       = 8'h41;
    localparam logic [7:0] ADDR_TIMER1       = 8'h42;
    localparam logic [7:0] ADDR_TIMER2       = 8'h43;
    localparam logic [7:0] ADDR_CMD_TRANSFER = 8'hF2;

    function automatic logic is_addr_phase(bus_state_t s);
        return (s == A_SETUP) || (s == A_STROBE) || (s == A_HOLD);
    endfunction

    function automatic logic is_data_phase(bus_state_t s);
        return (s == D_SETUP) || (s == D_STROBE) || (s == D_HOLD);
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Down-counter that times one bus state: load the state's length on entry,
// expired is high during the final cycle of that state.
module rtc_phase_timer
    import rtc_bus_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count > 1)) begin
            count <= count - 1'b1;
        end
    end

    // A loaded length of N leaves N-1 decrements before reaching 1.
    assign expired = (count <= 1);

endmodule

// File: rtl/rtc_bus_cycle.sv
// Single-transaction engine for the multiplexed address/data bus of the RTC chip.
// Optional feature macro RTC_RD_SYNC_EN: 2-flop synchronizer on read data with a stretched read strobe.
module rtc_bus_cycle
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 4
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       req,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       CSO,
    output logic       ADO,
    output logic       WRO,
    output logic       RDO,
    inout  wire  [7:0] Bus_Dato_Dir
);

`ifdef RTC_RD_SYNC_EN
    // Two extra strobe cycles cover the synchronizer delay; saturate at the counter limit.
    localparam int RD_PULSE_LEN = (T_PULSE + 2 > 255) ? 255 : T_PULSE + 2;
`else
    localparam int RD_PULSE_LEN = T_PULSE;
`endif

    localparam logic [CNT_W-1:0] SETUP_CNT    = CNT_W'(T_SETUP);
    localparam logic [CNT_W-1:0] PULSE_CNT    = CNT_W'(T_PULSE);
    localparam logic [CNT_W-1:0] RD_PULSE_CNT = CNT_W'(RD_PULSE_LEN);
    localparam logic [CNT_W-1:0] HOLD_CNT     = CNT_W'(T_HOLD);
    localparam logic [CNT_W-1:0] GAP_CNT      = CNT_W'(T_GAP);

    bus_state_t       state;
    bus_state_t       next_state;
    logic             rw_q;
    logic [7:0]       addr_q;
    logic [7:0]       wdata_q;
    logic [7:0]       dout;
    logic             oe;
    logic             accept;
    logic             cur_rw;
    logic [7:0]       cur_addr;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_expired;
    logic [7:0]       cap_bus;

    logic             cso_n;
    logic             ado_n;
    logic             wro_n;
    logic             rdo_n;
    logic             oe_n;
    logic [7:0]       dout_n;
    logic             busy_n;
    logic             done_n;

    assign accept   = (state == IDLE) && req;
    assign cur_rw   = accept ? rw   : rw_q;
    assign cur_addr = accept ? addr : addr_q;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (req)           next_state = A_SETUP;
            A_SETUP:  if (timer_expired) next_state = A_STROBE;
            A_STROBE: if (timer_expired) next_state = A_HOLD;
            A_HOLD:   if (timer_expired) next_state = GAP;
            GAP:      if (timer_expired) next_state = D_SETUP;
            D_SETUP:  if (timer_expired) next_state = D_STROBE;
            D_STROBE: if (timer_expired) next_state = D_HOLD;
            D_HOLD:   if (timer_expired) next_state = DONE;
            DONE:                        next_state = IDLE;
            default:                     next_state = IDLE;
        endcase
    end

    // The timer is reloaded on every state change with the length of the state being entered.
    always_comb begin
        timer_load = (next_state != state);
        timer_val  = '0;
        unique case (next_state)
            A_SETUP, D_SETUP: timer_val = SETUP_CNT;
            A_STROBE:         timer_val = PULSE_CNT;
            D_STROBE:         timer_val = rw_q ? RD_PULSE_CNT : PULSE_CNT;
            A_HOLD, D_HOLD:   timer_val = HOLD_CNT;
            GAP:              timer_val = GAP_CNT;
            default:          timer_val = '0;
        endcase
    end

    rtc_phase_timer u_timer (
        .clk      (CLK),
        .reset    (Reset),
        .load     (timer_load),
        .load_val (timer_val),
        .tick     (1'b1),
        .expired  (timer_expired)
    );

    // Pin values are decoded from the state being entered so every pin is a flop output.
    always_comb begin
        cso_n  = 1'b1;
        ado_n  = 1'b1;
        wro_n  = 1'b1;
        rdo_n  = 1'b1;
        oe_n   = 1'b0;
        dout_n = dout;
        busy_n = (next_state != IDLE);
        done_n = (next_state == DONE);
        if (is_addr_phase(next_state)) begin
            ado_n  = 1'b0;
            oe_n   = 1'b1;
            dout_n = cur_addr;
        end else if (is_data_phase(next_state) && !cur_rw) begin
            oe_n   = 1'b1;
            dout_n = wdata_q;
        end
        if (next_state == A_STROBE) begin
            cso_n = 1'b0;
            wro_n = 1'b0;
        end
        if (next_state == D_STROBE) begin
            cso_n = 1'b0;
            if (cur_rw) begin
                rdo_n = 1'b0;
            end else begin
                wro_n = 1'b0;
            end
        end
    end

`ifdef RTC_RD_SYNC_EN
    logic [7:0] sync_1;
    logic [7:0] sync_2;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= Bus_Dato_Dir;
            sync_2 <= sync_1;
        end
    end

    assign cap_bus = sync_2;
`else
    assign cap_bus = Bus_Dato_Dir;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= IDLE;
            CSO     <= 1'b1;
            ADO     <= 1'b1;
            WRO     <= 1'b1;
            RDO     <= 1'b1;
            oe      <= 1'b0;
            dout    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= next_state;
            CSO   <= cso_n;
            ADO   <= ado_n;
            WRO   <= wro_n;
            RDO   <= rdo_n;
            oe    <= oe_n;
            dout  <= dout_n;
            busy  <= busy_n;
            done  <= done_n;
            if (accept) begin
                rw_q    <= rw;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            // Capture on the last strobe cycle, while RDO is still low.
            if ((state == D_STROBE) && timer_expired && rw_q) begin
                rdata <= cap_bus;
            end
        end
    end

    assign Bus_Dato_Dir = oe ? dout : 8'hzz;

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Randomized scoreboard bench for rtc_bus_cycle with a behavioural model of the RTC chip on the bus.
module tb_rtc_bus_cycle;
    import rtc_bus_pkg::*;

    localparam int T_SETUP = 2;
    localparam int T_PULSE = 4;
    localparam int T_HOLD  = 2;
    localparam int T_GAP   = 4;
    localparam int LAT_WR  = 2 * (T_SETUP + T_PULSE + T_HOLD) + T_GAP;
`ifdef RTC_RD_SYNC_EN
    localparam int RD_PULSE = T_PULSE + 2;
`else
    localparam int RD_PULSE = T_PULSE;
`endif
    localparam int LAT_RD  = LAT_WR + RD_PULSE - T_PULSE;

    typedef struct {
        logic       is_read;
        logic [7:0] exp_rdata;
        int         accept_edge;
        int         latency;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       cso;
    logic       ado;
    logic       wro;
    logic       rdo;
    wire  [7:0] bus;

    logic       chip_oe = 1'b0;
    logic [7:0] chip_dout = 8'h00;
    logic [7:0] chip_mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] model_rdata = 8'h00;

    exp_t       exp_q [$];
    exp_t       mon_e;
    int         edge_count = 0;
    logic       reset_at_edge = 1'b1;
    int         n_checks = 0;
    int         n_fail = 0;
    int         wro_run = 0;
    int         rdo_run = 0;
    logic       prev_ado = 1'b1;
    logic [7:0] prev_bus = 8'h00;

    logic [7:0] addr_pool [10];

    assign bus = chip_oe ? chip_dout : 8'hzz;

    rtc_bus_cycle #(
        .T_SETUP (T_SETUP),
        .T_PULSE (T_PULSE),
        .T_HOLD  (T_HOLD),
        .T_GAP   (T_GAP)
    ) dut (
        .CLK          (clk),
        .Reset        (reset),
        .req          (req),
        .rw           (rw),
        .addr         (addr),
        .wdata        (wdata),
        .busy         (busy),
        .done         (done),
        .rdata        (rdata),
        .CSO          (cso),
        .ADO          (ado),
        .WRO          (wro),
        .RDO          (rdo),
        .Bus_Dato_Dir (bus)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        edge_count    <= edge_count + 1;
        reset_at_edge <= reset;
    end

    function automatic logic [7:0] init_val(int i);
        if (i == int'(ADDR_HORA)) return 8'h08;
        return 8'((i * 7) + 3);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, actual, expected, edge_count);
        end
    endtask

    // RTC chip: latches the address on the address-phase WRO rise, stores data on
    // the data-phase WRO rise, and drives the addressed register while RDO is low.
    initial begin
        logic       prev_wro;
        logic       lat_ado;
        logic [7:0] lat_bus;
        logic [7:0] chip_addr;
        prev_wro  = 1'b1;
        lat_ado   = 1'b1;
        lat_bus   = 8'h00;
        chip_addr = 8'h00;
        for (int i = 0; i < 256; i++) chip_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (!cso && !wro) begin
                lat_bus = bus;
                lat_ado = ado;
            end
            if (!prev_wro && wro) begin
                if (!lat_ado) chip_addr = lat_bus;
                else          chip_mem[chip_addr] = lat_bus;
            end
            prev_wro  = wro;
            chip_oe   = !rdo && !cso;
            chip_dout = chip_mem[chip_addr];
        end
    end

    // Monitor: scoreboard pop on done plus bus-protocol checks.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("latency", edge_count - mon_e.accept_edge, mon_e.latency);
                    checkOutput("rdata", int'(rdata), int'(mon_e.exp_rdata));
                    checkOutput("busy_at_done", int'(busy), 1);
                end
            end
            if (reset_at_edge) begin
                wro_run = 0;
                rdo_run = 0;
            end else begin
                if (!wro) begin
                    wro_run++;
                end else if (wro_run != 0) begin
                    checkOutput("wro_pulse_len", wro_run, T_PULSE);
                    wro_run = 0;
                end
                if (!rdo) begin
                    rdo_run++;
                    checkOutput("rdo_only_in_data_phase", int'(ado), 1);
                    checkOutput("bus_released_on_read", int'(dut.oe), 0);
                end else if (rdo_run != 0) begin
                    checkOutput("rdo_pulse_len", rdo_run, RD_PULSE);
                    rdo_run = 0;
                end
                if (!cso) begin
                    checkOutput("ado_stable_under_cs", int'(ado), int'(prev_ado));
                    if (!wro) checkOutput("bus_stable_under_cs", int'(bus), int'(prev_bus));
                end
            end
        end
        prev_ado = ado;
        prev_bus = bus;
    end

    task automatic waitIdle();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((busy !== 1'b0) && (guard < 200)) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) checkOutput("idle_timeout", guard, 0);
    endtask

    function automatic exp_t buildExpect(input logic r, input logic [7:0] a, input logic [7:0] d, input int acc);
        exp_t e;
        if (r) model_rdata = ref_mem[a];
        else   ref_mem[a] = d;
        e.is_read     = r;
        e.exp_rdata   = model_rdata;
        e.accept_edge = acc;
        e.latency     = r ? LAT_RD : LAT_WR;
        return e;
    endfunction

    task automatic applyStimulus(input logic r, input logic [7:0] a, input logic [7:0] d);
        waitIdle();
        req   = 1'b1;
        rw    = r;
        addr  = a;
        wdata = d;
        exp_q.push_back(buildExpect(r, a, d, edge_count + 1));
        @(posedge clk);
        #2 req = 1'b0;
    endtask

    task automatic applyBackToBack(input logic r1, input logic [7:0] a1, input logic [7:0] d1,
                                   input logic r2, input logic [7:0] a2, input logic [7:0] d2);
        exp_t e1;
        exp_t e2;
        int   guard;
        waitIdle();
        req   = 1'b1;
        rw    = r1;
        addr  = a1;
        wdata = d1;
        e1 = buildExpect(r1, a1, d1, edge_count + 1);
        exp_q.push_back(e1);
        @(posedge clk);
        #2;
        rw    = r2;
        addr  = a2;
        wdata = d2;
        // DONE occupies one cycle, IDLE one more, then the held req is taken.
        e2 = buildExpect(r2, a2, d2, e1.accept_edge + e1.latency + 2);
        exp_q.push_back(e2);
        guard = 0;
        while ((edge_count < e2.accept_edge) && (guard < 200)) begin
            @(negedge clk);
            guard++;
        end
        req = 1'b0;
    endtask

    initial begin
        int guard;
        addr_pool = '{ADDR_SEG, ADDR_MIN, ADDR_HORA, ADDR_DIA, ADDR_MES, ADDR_ANO,
                      ADDR_TIMER0, ADDR_TIMER1, ADDR_TIMER2, ADDR_CMD_TRANSFER};
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_cso", int'(cso), 1);
        checkOutput("reset_ado", int'(ado), 1);
        checkOutput("reset_wro", int'(wro), 1);
        checkOutput("reset_rdo", int'(rdo), 1);
        checkOutput("reset_bus_released", int'(dut.oe), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_rdata", int'(rdata), 0);

        $display("[TB] directed write/read");
        applyStimulus(1'b0, ADDR_MIN, 8'h10);
        applyStimulus(1'b1, ADDR_HORA, 8'h00);
        applyStimulus(1'b1, ADDR_MIN, 8'h00);

        $display("[TB] back-to-back and ignored mid-transaction req");
        applyBackToBack(1'b0, ADDR_SEG, 8'h3C, 1'b1, ADDR_SEG, 8'h00);
        applyStimulus(1'b0, ADDR_MES, 8'h77);
        repeat (6) @(negedge clk);
        req  = 1'b1;
        rw   = 1'b1;
        addr = ADDR_ANO;
        @(negedge clk);
        req  = 1'b0;
        applyStimulus(1'b1, ADDR_MES, 8'h00);

        $display("[TB] reset during write data strobe");
        applyStimulus(1'b0, ADDR_DIA, 8'hA5);
        guard = 0;
        while (!((cso == 1'b0) && (ado == 1'b1)) && (guard < 100)) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reach_d_strobe", int'(guard < 100), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        model_rdata = 8'h00;
        checkOutput("abort_cso", int'(cso), 1);
        checkOutput("abort_ado", int'(ado), 1);
        checkOutput("abort_wro", int'(wro), 1);
        checkOutput("abort_rdo", int'(rdo), 1);
        checkOutput("abort_bus_released", int'(dut.oe), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_rdata", int'(rdata), 0);
        applyStimulus(1'b1, ADDR_DIA, 8'h00);
        applyStimulus(1'b0, ADDR_TIMER0, 8'h5E);

        $display("[TB] random transactions");
        for (int n = 0; n < 24; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), addr_pool[$urandom_range(0, 9)], 8'($urandom));
        end

        repeat (30) @(negedge clk);
        guard = 0;
        while ((exp_q.size() != 0) && (guard < 100)) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
